// File: rtl/fp8_op_arbiter_if.sv
// Request, datapath and response signals between the FP8 arbiter and its neighbours.
// The slave modport is the arbiter side; master is the requester/datapath side.
interface fp8_op_arbiter_if #(
   parameter int unsigned W = 8
);
   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req0_op;
   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         req1_op;
   logic         dp_valid;
   logic [W-1:0] dp_a;
   logic [W-1:0] dp_b;
   logic         dp_op;
   logic [W-1:0] dp_result;
   logic         rsp0_valid;
   logic [W-1:0] rsp0_data;
   logic         rsp1_valid;
   logic [W-1:0] rsp1_data;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  dp_result,
      output req0_ready, req1_ready,
      output dp_valid, dp_a, dp_b, dp_op,
      output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output dp_result,
      input  req0_ready, req1_ready,
      input  dp_valid, dp_a, dp_b, dp_op,
      input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
   );
endinterface

// File: rtl/fp8_op_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP8 datapath between two requesters,
// with a tag pipe that steers each result back to the requester that issued it.
module fp8_op_arbiter #(
   parameter int unsigned LAT = 2,
   parameter int unsigned W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_ena,
   output logic                o_busy,
   fp8_op_arbiter_if.slave     bus
);
   localparam int unsigned CNT_W = $clog2(LAT + 3);

   logic             w_grant_vld;
   logic             w_grant;
   logic [W-1:0]     w_sel_a;
   logic [W-1:0]     w_sel_b;
   logic             w_sel_op;
   logic             w_out_vld;
   logic             w_out_tag;
   logic             w_dec;
   logic [CNT_W-1:0] w_cnt_nxt;

   logic             r_last_grant;
   logic             r_dp_valid;
   logic             r_dp_tag;
   logic             r_dp_op;
   logic [W-1:0]     r_dp_a;
   logic [W-1:0]     r_dp_b;
   logic [LAT-1:0]   r_pipe_vld;
   logic [LAT-1:0]   r_pipe_tag;
   logic             r_rsp0_valid;
   logic             r_rsp1_valid;
   logic [W-1:0]     r_rsp0_data;
   logic [W-1:0]     r_rsp1_data;
   logic [CNT_W-1:0] r_cnt;

   // Grant: under contention, the requester not served last time wins.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant     = 1'b0;
      if (i_ena) begin
         if (bus.req0_valid && bus.req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant     = ~r_last_grant;
         end else if (bus.req0_valid) begin
            w_grant_vld = 1'b1;
            w_grant     = 1'b0;
         end else if (bus.req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant     = 1'b1;
         end
      end
      bus.req0_ready = w_grant_vld & ~w_grant;
      bus.req1_ready = w_grant_vld &  w_grant;
   end

   assign w_sel_a  = w_grant ? bus.req1_a  : bus.req0_a;
   assign w_sel_b  = w_grant ? bus.req1_b  : bus.req0_b;
   assign w_sel_op = w_grant ? bus.req1_op : bus.req0_op;

   // Launch register: operands held between launches, strobe only on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_dp_valid   <= 1'b0;
         r_dp_tag     <= 1'b0;
         r_dp_op      <= 1'b0;
         r_dp_a       <= '0;
         r_dp_b       <= '0;
      end else begin
         r_dp_valid <= w_grant_vld;
         if (w_grant_vld) begin
            r_last_grant <= w_grant;
            r_dp_tag     <= w_grant;
            r_dp_op      <= w_sel_op;
            r_dp_a       <= w_sel_a;
            r_dp_b       <= w_sel_b;
         end
      end
   end

   // Tag pipe tracks the datapath so its last stage lines up with dp_result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe_vld <= '0;
         r_pipe_tag <= '0;
      end else begin
         r_pipe_vld[0] <= r_dp_valid;
         r_pipe_tag[0] <= r_dp_tag;
         for (int i = 1; i < int'(LAT); i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_tag[i] <= r_pipe_tag[i-1];
         end
      end
   end

   assign w_out_vld = r_pipe_vld[LAT-1];
   assign w_out_tag = r_pipe_tag[LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_rsp0_data  <= '0;
         r_rsp1_data  <= '0;
      end else begin
         r_rsp0_valid <= w_out_vld & ~w_out_tag;
         r_rsp1_valid <= w_out_vld &  w_out_tag;
         if (w_out_vld && !w_out_tag) r_rsp0_data <= bus.dp_result;
         if (w_out_vld &&  w_out_tag) r_rsp1_data <= bus.dp_result;
      end
   end

   // In-flight count: bounded by pipe depth, so it cannot wrap.
   assign w_dec = r_rsp0_valid | r_rsp1_valid;

   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_grant_vld, w_dec})
         2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
         2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= w_cnt_nxt;
   end

   assign o_busy         = (r_cnt != '0);
   assign bus.dp_valid   = r_dp_valid;
   assign bus.dp_a       = r_dp_a;
   assign bus.dp_b       = r_dp_b;
   assign bus.dp_op      = r_dp_op;
   assign bus.rsp0_valid = r_rsp0_valid;
   assign bus.rsp0_data  = r_rsp0_data;
   assign bus.rsp1_valid = r_rsp1_valid;
   assign bus.rsp1_data  = r_rsp1_data;
endmodule

// File: tb/tb_fp8_op_arbiter.sv
// Bench for fp8_op_arbiter: vector table for grant sequences, scoreboard for responses,
// hand sequences for busy, async reset and the simultaneous accept/response case.
module tb_fp8_op_arbiter;
   localparam int unsigned LAT = 2;
   localparam int unsigned W   = 8;

   logic clk;
   logic rst_n;
   logic ena;
   logic busy;
   int   cyc;
   int   n_tests;
   int   n_fail;

   fp8_op_arbiter_if #(.W(W)) bus ();

   fp8_op_arbiter #(.LAT(LAT), .W(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_ena  (ena),
      .o_busy (busy),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath model: (a+b) mod 256 delayed LAT cycles.
   logic [W-1:0] m_d [LAT];
   always_ff @(posedge clk) begin
      m_d[0] <= W'(bus.dp_a + bus.dp_b);
      for (int i = 1; i < int'(LAT); i++) m_d[i] <= m_d[i-1];
   end
   assign bus.dp_result = m_d[LAT-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   typedef struct {
      logic         tag;
      logic [W-1:0] data;
      int           cyc;
   } exp_t;
   exp_t sb[$];

   // Scoreboard: push on accept, expect the response exactly LAT+2 cycles later.
   always @(negedge clk) begin
      logic [1:0] exp_v;
      exp_t       e;
      if (rst_n) begin
         exp_v = 2'b00;
         if (sb.size() > 0 && sb[0].cyc + int'(LAT) + 2 == cyc)
            exp_v = sb[0].tag ? 2'b10 : 2'b01;
         chk("rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'(exp_v));
         if (exp_v != 2'b00) begin
            e = sb.pop_front();
            if (e.tag) chk("rsp1_data", 32'(bus.rsp1_data), 32'(e.data));
            else       chk("rsp0_data", 32'(bus.rsp0_data), 32'(e.data));
         end
         if (bus.req0_valid && bus.req0_ready)
            sb.push_back('{tag: 1'b0, data: W'(bus.req0_a + bus.req0_b), cyc: cyc});
         if (bus.req1_valid && bus.req1_ready)
            sb.push_back('{tag: 1'b1, data: W'(bus.req1_a + bus.req1_b), cyc: cyc});
      end
   end

   typedef struct {
      logic         ena, v0, v1;
      logic [W-1:0] a0, b0, a1, b1;
      logic         r0, r1, dpv;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic e, input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                      input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                      input logic r0, input logic r1, input logic dpv);
      vecs.push_back('{ena: e, v0: v0, v1: v1, a0: a0, b0: b0, a1: a1, b1: b1,
                       r0: r0, r1: r1, dpv: dpv});
   endtask

   task automatic set_in(input logic e, input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1);
      ena = e;
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = 1'b1;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 with reset released.
   task automatic do_reset(input string name);
      #2;
      rst_n = 1'b0;
      sb.delete();
      set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
      #1;
      chk({name, "_dp_valid"}, 32'(bus.dp_valid), 32'd0);
      chk({name, "_rsp_v"}, 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_dp_a"}, 32'(bus.dp_a), 32'd0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic run_vecs(input string name);
      foreach (vecs[i]) begin
         set_in(vecs[i].ena, vecs[i].v0, vecs[i].a0, vecs[i].b0,
                vecs[i].v1, vecs[i].a1, vecs[i].b1);
         @(negedge clk);
         chk({name, "_ready0"}, 32'(bus.req0_ready), 32'(vecs[i].r0));
         chk({name, "_ready1"}, 32'(bus.req1_ready), 32'(vecs[i].r1));
         chk({name, "_dp_valid"}, 32'(bus.dp_valid), 32'(vecs[i].dpv));
         step();
      end
      vecs.delete();
      set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
      step();
      do_reset("init");

      // Single op from req0: 3+2 returns on rsp0.
      add(1, 1, 8'h03, 8'h02, 0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_vecs("t1");

      // Contention for 6 cycles alternates starting with req0.
      do_reset("rst2");
      for (int i = 0; i < 6; i++)
         add(1, 1, 8'h01, 8'h04, 1, 8'h05, 8'h03, (i % 2 == 0), (i % 2 == 1), (i != 0));
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_vecs("t2");

      // Enable dropped after a req0 grant; req1 wins when enable returns.
      do_reset("rst4");
      add(1, 1, 8'h10, 8'h20, 1, 8'h30, 8'h40, 1, 0, 0);
      add(0, 1, 8'h10, 8'h20, 1, 8'h30, 8'h40, 0, 0, 1);
      add(0, 1, 8'h10, 8'h20, 1, 8'h30, 8'h40, 0, 0, 0);
      add(0, 1, 8'h10, 8'h20, 1, 8'h30, 8'h40, 0, 0, 0);
      add(1, 1, 8'h10, 8'h20, 1, 8'h30, 8'h40, 0, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_vecs("t4");

      // Four back-to-back req1 ops; busy covers first accept to last response.
      do_reset("rst3");
      for (int k = 0; k < 10; k++) begin
         set_in(1'b1, 1'b0, 8'h00, 8'h00, (k < 4), 8'h07, 8'h02);
         @(negedge clk);
         chk("t3_ready1", 32'(bus.req1_ready), 32'(k < 4));
         chk("t3_busy", 32'(busy), 32'(k >= 1 && k <= 7));
         if (k == 4) chk("t3_cnt_peak", 32'(dut.r_cnt), 32'd4);
         step();
      end

      // Accept coinciding with a response keeps the count steady.
      do_reset("rst6");
      for (int k = 0; k < 6; k++) begin
         set_in(1'b1, (k == 0 || k == 2 || k == 4), 8'h11, 8'h22, 1'b0, 8'h00, 8'h00);
         @(negedge clk);
         if (k == 4) begin
            chk("t6_rsp0_coincide", 32'(bus.rsp0_valid), 32'd1);
            chk("t6_ready0_coincide", 32'(bus.req0_ready), 32'd1);
            chk("t6_cnt_before", 32'(dut.r_cnt), 32'd2);
         end
         if (k == 5) begin
            chk("t6_cnt_after", 32'(dut.r_cnt), 32'd2);
            chk("t6_busy_after", 32'(busy), 32'd1);
         end
         step();
      end
      for (int k = 0; k < 6; k++) step();

      // Async reset with three ops in flight discards them all.
      do_reset("rst5a");
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 1'b1, 8'h03, 8'h02, 1'b0, 8'h00, 8'h00);
         step();
      end
      set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
      do_reset("t5_mid");
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("t5_busy_post", 32'(busy), 32'd0);
         step();
      end
      set_in(1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 8'h02, 8'h02);
      @(negedge clk);
      chk("t5_ready0_first", 32'(bus.req0_ready), 32'd1);
      chk("t5_ready1_first", 32'(bus.req1_ready), 32'd0);
      step();
      set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);

      // Drain, bounded.
      for (int k = 0; k < 20 && sb.size() != 0; k++) step();
      step();
      chk("sb_drain", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
